// File: rtl/fifo_arbiter.sv
// Two-requester write arbiter and read-side drainer for a byte FIFO with 1-cycle read latency.
// A 2-entry output buffer with valid/ready keeps 1 byte/cycle through the latency; flush drains everything.
module fifo_arbiter #(
  parameter int   DATA_W  = 8,
  parameter int   DEPTH   = 16,
  parameter logic RR_INIT = 1'b0,
  localparam int  LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] fifo_din_o,
  output logic              fifo_wren_o,
  input  logic              fifo_full_i,
  output logic              fifo_rden_o,
  input  logic [DATA_W-1:0] fifo_dout_i,
  input  logic              fifo_empty_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              busy_o
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              inflight_q;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic       run;
  logic       grant;
  logic       win;
  logic       pop;
  logic       push;
  logic [2:0] occ;

  assign run = !rst_i && (state_q == ST_RUN);

  // Write side: a lone requester wins outright, a tie goes to the round-robin pointer.
  assign grant       = run && !fifo_full_i && (req0_i || req1_i);
  assign win         = (req0_i && req1_i) ? rr_q : req1_i;
  assign ack0_o      = grant && !win;
  assign ack1_o      = grant && win;
  assign fifo_wren_o = grant;
  assign fifo_din_o  = win ? data1_i : data0_i;

  assign out_valid_o = (state_q == ST_RUN) && (buf_cnt_q != 2'd0);
  assign out_data_o  = buf0_q;
  assign pop         = out_valid_o && out_ready_i;
  assign push        = inflight_q && (state_q == ST_RUN);

  // Buffered plus in-flight bytes, net of this cycle's pop, must leave room for one more.
  assign occ         = 3'(buf_cnt_q) + 3'(inflight_q);
  assign fifo_rden_o = !rst_i && !fifo_empty_i &&
                       ((state_q == ST_FLUSH) || (occ < (3'd2 + 3'(pop))));

  assign level_o = level_q;
  assign busy_o  = (state_q == ST_FLUSH);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    rr_d      = grant ? !win : rr_q;
    buf_cnt_d = buf_cnt_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    level_d   = level_q;

    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = fifo_dout_i;
        else                   buf1_d = fifo_dout_i;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_dout_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout_i;
        end
      end
      default: ;
    endcase

    case ({fifo_wren_o, fifo_rden_o})
      2'b10:   if (level_q != LVL_W'(DEPTH)) level_d = level_q + LVL_W'(1);
      2'b01:   if (level_q != '0)            level_d = level_q - LVL_W'(1);
      default: ;
    endcase

    // Entering FLUSH drops the buffer; bytes still in flight land while in FLUSH and are ignored.
    if (state_q == ST_RUN) begin
      if (flush_i) begin
        state_d   = ST_FLUSH;
        buf_cnt_d = 2'd0;
      end
    end else if (fifo_empty_i && !inflight_q) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      rr_q       <= RR_INIT;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      // NOTE: the buffer storage is reset as well so out_data_o reads zero after reset.
      buf0_q     <= '0;
      buf1_q     <= '0;
      level_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
      state_q    <= state_d;
      rr_q       <= rr_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= fifo_rden_o;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      level_q    <= level_d;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: a queue-based FIFO and requester agents drive the DUT,
// a queue model predicts every output each cycle, and directed tests pin literal results.
module tb_fifo_arbiter;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0]    data0 = '0, data1 = '0;
  logic             ack0, ack1, fifo_wren, fifo_rden, out_valid, busy;
  logic [DW-1:0]    fifo_din, out_data;
  logic [DW-1:0]    fifo_dout = '0;
  logic             fifo_full, fifo_empty;
  logic             out_ready = 1'b1;
  logic [LVL_W-1:0] level;
  logic             force_full = 1'b0;
  int               fifo_cnt = 0;

  assign fifo_full  = force_full || (fifo_cnt >= DEPTH);
  assign fifo_empty = (fifo_cnt == 0);

  always #5 clk = ~clk;

  fifo_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .RR_INIT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req0_i(req0), .req1_i(req1), .data0_i(data0), .data1_i(data1),
    .ack0_o(ack0), .ack1_o(ack1),
    .fifo_din_o(fifo_din), .fifo_wren_o(fifo_wren), .fifo_full_i(fifo_full),
    .fifo_rden_o(fifo_rden), .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .level_o(level), .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: FIFO contents, requester queues, and what the DUT did last cycle.
  logic [DW-1:0] fifo_mem[$];
  logic [DW-1:0] rq0[$], rq1[$];
  logic          e_wr = 0, e_rd = 0, e_rst = 1, e_ack0 = 0, e_ack1 = 0;
  logic [DW-1:0] e_wdata = '0;
  logic [DW-1:0] junk;

  always @(posedge clk) begin
    #1;
    if (e_rst) begin
      fifo_mem.delete();
    end else begin
      if (e_rd && fifo_mem.size() > 0) fifo_dout = fifo_mem.pop_front();
      if (e_wr) fifo_mem.push_back(e_wdata);
      if (e_ack0 && rq0.size() > 0) junk = rq0.pop_front();
      if (e_ack1 && rq1.size() > 0) junk = rq1.pop_front();
    end
    fifo_cnt = fifo_mem.size();
    req0 = (rq0.size() > 0);
    if (req0) data0 = rq0[0];
    req1 = (rq1.size() > 0);
    if (req1) data1 = rq1[0];
  end

  // Model state: run/flush mode, tie-break owner, read in flight, buffered bytes, expected stream.
  bit            started = 0;
  bit            m_run = 1, m_rr = 0, m_inflight = 0;
  logic [DW-1:0] m_buf[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] out_log[$];
  bit            grant_log[$];
  int            flush_rd_cnt = 0;
  int            level_max = 0;
  bit            c_valid, c_pop, c_grant, c_win, c_rden;

  always @(negedge clk) begin
    if (started) begin
      c_valid = m_run && (m_buf.size() > 0);
      c_pop   = c_valid && out_ready;
      c_grant = !rst && m_run && !fifo_full && (req0 || req1);
      c_win   = (req0 && req1) ? m_rr : req1;
      c_rden  = !rst && !fifo_empty &&
                (!m_run || (m_buf.size() + int'(m_inflight) - int'(c_pop) < 2));

      check("ack0", ack0, c_grant && !c_win);
      check("ack1", ack1, c_grant && c_win);
      check("fifo_wren", fifo_wren, c_grant);
      if (c_grant) check("fifo_din", fifo_din, c_win ? data1 : data0);
      check("fifo_rden", fifo_rden, c_rden);
      check("out_valid", out_valid, c_valid);
      if (c_valid) check("out_data", out_data, m_buf[0]);
      check("busy", busy, !m_run);
      check("level", level, fifo_cnt);

      if (c_pop) begin
        check("out_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          check("out_stream", out_data, sb[0]);
          junk = sb.pop_front();
        end
        out_log.push_back(out_data);
      end
      if (c_grant) grant_log.push_back(c_win);
      if (fifo_rden && busy) flush_rd_cnt++;
      if (int'(level) > level_max) level_max = int'(level);

      if (rst) begin
        m_run = 1; m_rr = 0; m_inflight = 0;
        m_buf.delete(); sb.delete();
      end else begin
        if (c_pop) junk = m_buf.pop_front();
        if (m_inflight && m_run) m_buf.push_back(fifo_dout);
        if (c_grant) begin
          sb.push_back(c_win ? data1 : data0);
          m_rr = !c_win;
        end
        if (m_run && flush) begin
          m_run = 0;
          m_buf.delete();
          sb.delete();
        end else if (!m_run && fifo_empty && !m_inflight) begin
          m_run = 1;
        end
        m_inflight = c_rden;
      end
    end
    e_wr = fifo_wren; e_wdata = fifo_din; e_rd = fifo_rden;
    e_rst = rst; e_ack0 = ack0; e_ack1 = ack1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && !req0 && !req1 && fifo_cnt == 0 &&
             !busy && sb.size() == 0 && m_buf.size() == 0 && !m_inflight) && i < 200) begin
      tick();
      i++;
    end
    check({name, "_idle_timeout"}, i < 200, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq0.delete();
    rq1.delete();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int i;
    @(posedge clk);
    #2;
    started = 1;
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_level", level, 0);
    check("reset_busy", busy, 1'b0);

    // Test 1: single requester back-to-back
    tick();
    out_log.delete(); grant_log.delete(); level_max = 0;
    for (int k = 0; k < 4; k++) rq0.push_back(8'h11 + 8'(k));
    wait_idle("t1");
    check("t1_out_count", out_log.size(), 4);
    for (int k = 0; k < 4 && k < out_log.size(); k++)
      check("t1_out_byte", out_log[k], 8'h11 + 8'(k));
    check("t1_level_peak", level_max, 1);
    check("t1_grants", grant_log.size(), 4);

    // Test 2: both requesters, round-robin from requester 0
    do_reset();
    out_log.delete(); grant_log.delete();
    rq0.push_back(8'h21); rq0.push_back(8'h22);
    rq1.push_back(8'h31); rq1.push_back(8'h32);
    wait_idle("t2");
    check("t2_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("t2_grant0", grant_log[0], 1'b0);
      check("t2_grant1", grant_log[1], 1'b1);
      check("t2_grant2", grant_log[2], 1'b0);
      check("t2_grant3", grant_log[3], 1'b1);
    end
    check("t2_out_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("t2_out0", out_log[0], 8'h21);
      check("t2_out1", out_log[1], 8'h31);
      check("t2_out2", out_log[2], 8'h22);
      check("t2_out3", out_log[3], 8'h32);
    end

    // Test 3: full blocks the grant, release grants the same cycle
    out_log.delete();
    force_full = 1'b1;
    rq1.push_back(8'h41);
    tick(3);
    @(negedge clk); #1;
    check("t3_req_pending", req1, 1'b1);
    check("t3_no_ack", ack1, 1'b0);
    check("t3_no_wren", fifo_wren, 1'b0);
    tick();
    force_full = 1'b0;
    @(negedge clk); #1;
    check("t3_ack_on_release", ack1, 1'b1);
    check("t3_wren_on_release", fifo_wren, 1'b1);
    check("t3_din", fifo_din, 8'h41);
    wait_idle("t3");
    check("t3_out", out_log.size() == 1 && out_log[0] == 8'h41, 1'b1);

    // Test 4: back-pressure holds two in the buffer and three in the FIFO
    out_log.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) rq0.push_back(8'h51 + 8'(k));
    tick(15);
    @(negedge clk); #1;
    check("t4_valid", out_valid, 1'b1);
    check("t4_head", out_data, 8'h51);
    check("t4_level", level, 3);
    check("t4_rden_stopped", fifo_rden, 1'b0);
    tick();
    out_ready = 1'b1;
    wait_idle("t4");
    check("t4_out_count", out_log.size(), 5);
    for (int k = 0; k < 5 && k < out_log.size(); k++)
      check("t4_out_byte", out_log[k], 8'h51 + 8'(k));

    // Test 5: flush with six in the FIFO and a full buffer
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) rq0.push_back(8'h61 + 8'(k));
    tick(20);
    @(negedge clk); #1;
    check("t5_level_before", level, 6);
    check("t5_valid_before", out_valid, 1'b1);
    tick();
    flush_rd_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk); #1;
    check("t5_busy", busy, 1'b1);
    check("t5_valid_in_flush", out_valid, 1'b0);
    i = 0;
    while (busy && i < 100) begin
      tick();
      i++;
    end
    check("t5_flush_timeout", i < 100, 1'b1);
    check("t5_rden_pulses", flush_rd_cnt, 6);
    check("t5_level_after", level, 0);
    out_ready = 1'b1;
    out_log.delete();
    rq0.push_back(8'hA5);
    wait_idle("t5");
    check("t5_first_after_flush", out_log.size() == 1 && out_log[0] == 8'hA5, 1'b1);

    // Test 6: reset with one byte buffered and one read in flight
    out_ready = 1'b0;
    out_log.delete();
    rq0.push_back(8'h71);
    i = 0;
    while (!out_valid && i < 50) begin
      tick();
      i++;
    end
    check("t6_first_buffered", out_valid, 1'b1);
    rq0.push_back(8'h72);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!fifo_rden && i < 50);
    check("t6_second_read", fifo_rden, 1'b1);
    tick();
    rst = 1'b1;
    rq0.delete();
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_data", out_data, 8'h00);
    check("t6_level", level, 0);
    check("t6_busy", busy, 1'b0);
    tick();
    out_ready = 1'b1;
    tick(10);
    check("t6_no_stale", out_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
